// File: rtl/cnn_sched_pkg.sv
// Shared types and layer geometry for the 3x3 convolution layer scheduler.
package cnn_sched_pkg;

  localparam int IMG_W_D   = 32;
  localparam int IMG_H_D   = 32;
  localparam int K_D       = 3;
  localparam int NUM_KER_D = 8;

  localparam int OUT_W = IMG_W_D - K_D + 1;
  localparam int OUT_H = IMG_H_D - K_D + 1;
  localparam int NUM_W = NUM_KER_D * K_D * K_D;
  localparam int NUM_B = NUM_KER_D;

  typedef logic [4:0] coord_t;

  typedef enum logic [2:0] {IDLE, LOAD, SWEEP, DRAIN, DONE} state_e;

endpackage

// File: rtl/cnn_layer_sched_if.sv
// Scheduler <-> datapath/memory signal bundle. perf_stall exists only when
// CNN_SCHED_PERF_EN is defined.
interface cnn_layer_sched_if;
  import cnn_sched_pkg::*;

  logic       start;
  logic       busy;
  logic       done;
  logic       w_rd_en;
  logic [6:0] w_rd_addr;
  logic       b_rd_en;
  logic [2:0] b_rd_addr;
  logic       cfg_ld_en;
  logic       cfg_ld_bias;
  logic [6:0] cfg_ld_idx;
  logic       win_valid;
  logic       win_ready;
  coord_t     win_row;
  coord_t     win_col;
  logic       res_wr_en;
  coord_t     res_row;
  coord_t     res_col;
`ifdef CNN_SCHED_PERF_EN
  logic [15:0] perf_stall;
`endif

  modport master (
`ifdef CNN_SCHED_PERF_EN
    output perf_stall,
`endif
    input  start, win_ready,
    output busy, done, w_rd_en, w_rd_addr, b_rd_en, b_rd_addr,
    output cfg_ld_en, cfg_ld_bias, cfg_ld_idx,
    output win_valid, win_row, win_col, res_wr_en, res_row, res_col
  );

  modport slave (
`ifdef CNN_SCHED_PERF_EN
    input  perf_stall,
`endif
    output start, win_ready,
    input  busy, done, w_rd_en, w_rd_addr, b_rd_en, b_rd_addr,
    input  cfg_ld_en, cfg_ld_bias, cfg_ld_idx,
    input  win_valid, win_row, win_col, res_wr_en, res_row, res_col
  );

endinterface

// File: rtl/cnn_sched_delay_line.sv
// Fixed-depth shift of accepted window coordinates, mirroring datapath latency.
module cnn_sched_delay_line
  import cnn_sched_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  coord_t in_row,
  input  coord_t in_col,
  output logic   out_valid,
  output coord_t out_row,
  output coord_t out_col,
  output logic   pending
);

  logic   [STAGES:1] vld_pipe;
  coord_t [STAGES:1] row_pipe;
  coord_t [STAGES:1] col_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      row_pipe <= '0;
      col_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      row_pipe[1] <= in_row;
      col_pipe[1] <= in_col;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        row_pipe[s] <= row_pipe[s-1];
        col_pipe[s] <= col_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_row   = row_pipe[STAGES];
  assign out_col   = col_pipe[STAGES];

  // Entries that will still be in flight after the next edge; the output
  // stage itself is excluded so DONE lands right after the last write.
  always_comb begin
    pending = 1'b0;
    for (int s = 1; s < STAGES; s++) pending = pending | vld_pipe[s];
  end

endmodule

// File: rtl/cnn_layer_sched.sv
// Single-layer 3x3 conv sequencer: weight/bias load, window raster sweep,
// result write tracking. Optional stall counter under CNN_SCHED_PERF_EN.
module cnn_layer_sched
  import cnn_sched_pkg::*;
#(
  parameter int IMG_W    = IMG_W_D,
  parameter int IMG_H    = IMG_H_D,
  parameter int K        = K_D,
  parameter int NUM_KER  = NUM_KER_D,
  parameter int PIPE_LAT = 4
) (
  input logic                clk,
  input logic                rst,
  cnn_layer_sched_if.master  bus
);

  localparam coord_t     LAST_COL = coord_t'(IMG_W - K);
  localparam coord_t     LAST_ROW = coord_t'(IMG_H - K);
  localparam logic [6:0] NW       = 7'(NUM_KER * K * K);
  localparam logic [6:0] W_LAST   = 7'(NUM_KER * K * K - 1);
  localparam logic [6:0] LD_LAST  = 7'(NUM_KER * K * K + NUM_KER - 1);

  state_e     state;
  logic [6:0] ld_cnt;
  logic [6:0] ld_nxt;
  logic       accept;
  logic       pending;

  assign ld_nxt = ld_cnt + 7'd1;
  assign accept = bus.win_valid & bus.win_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      ld_cnt          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.w_rd_en     <= 1'b0;
      bus.w_rd_addr   <= '0;
      bus.b_rd_en     <= 1'b0;
      bus.b_rd_addr   <= '0;
      bus.cfg_ld_en   <= 1'b0;
      bus.cfg_ld_bias <= 1'b0;
      bus.cfg_ld_idx  <= '0;
      bus.win_valid   <= 1'b0;
      bus.win_row     <= '0;
      bus.win_col     <= '0;
    end else begin
      // Memory returns data one cycle after the strobe; tell the datapath then.
      bus.cfg_ld_en   <= bus.w_rd_en | bus.b_rd_en;
      bus.cfg_ld_bias <= bus.b_rd_en;
      bus.cfg_ld_idx  <= bus.b_rd_en ? 7'(bus.b_rd_addr) : bus.w_rd_addr;
      bus.done        <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state         <= LOAD;
          bus.busy      <= 1'b1;
          bus.w_rd_en   <= 1'b1;
          bus.w_rd_addr <= '0;
          ld_cnt        <= '0;
        end
        LOAD: begin
          ld_cnt <= ld_nxt;
          if (ld_cnt < W_LAST) begin
            bus.w_rd_addr <= ld_nxt;
          end else if (ld_cnt < LD_LAST) begin
            bus.w_rd_en   <= 1'b0;
            bus.w_rd_addr <= '0;
            bus.b_rd_en   <= 1'b1;
            bus.b_rd_addr <= 3'(ld_nxt - NW);
          end else begin
            bus.b_rd_en   <= 1'b0;
            bus.b_rd_addr <= '0;
            ld_cnt        <= '0;
            state         <= SWEEP;
            bus.win_valid <= 1'b1;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
          end
        end
        SWEEP: if (bus.win_ready) begin
          if (bus.win_col == LAST_COL) begin
            bus.win_col <= '0;
            if (bus.win_row == LAST_ROW) begin
              bus.win_row   <= '0;
              bus.win_valid <= 1'b0;
              state         <= DRAIN;
            end else begin
              bus.win_row <= bus.win_row + 5'd1;
            end
          end else begin
            bus.win_col <= bus.win_col + 5'd1;
          end
        end
        DRAIN: if (!pending) begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cnn_sched_delay_line #(.STAGES(PIPE_LAT)) u_res_dl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_row    (bus.win_row),
    .in_col    (bus.win_col),
    .out_valid (bus.res_wr_en),
    .out_row   (bus.res_row),
    .out_col   (bus.res_col),
    .pending   (pending)
  );

`ifdef CNN_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus.perf_stall <= '0;
    else if (state == IDLE && bus.start)
      bus.perf_stall <= '0;
    else if (bus.win_valid && !bus.win_ready && bus.perf_stall != 16'hFFFF)
      bus.perf_stall <= bus.perf_stall + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Randomized self-checking bench for cnn_layer_sched against a raster/latency
// model; the stall-counter test runs when CNN_SCHED_PERF_EN is defined.
module tb_cnn_layer_sched;

  localparam int PL   = 4;
  localparam int OW   = 30;
  localparam int NWIN = 900;

  typedef struct {int cyc; int a; int b;} ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   c0 = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   stab_err = 0;
  int   stab_base = 0;
  logic       prev_stall = 1'b0;
  logic [4:0] prev_row = '0;
  logic [4:0] prev_col = '0;

  ev_t w_q[$], b_q[$], cfg_q[$], acc_q[$], res_q[$], done_q[$];

  cnn_layer_sched_if bus();

  cnn_layer_sched #(.PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logger; cycle numbers are relative to the cycle start was raised in.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.w_rd_en)   w_q.push_back('{cyc - c0, int'(bus.w_rd_addr), 0});
      if (bus.b_rd_en)   b_q.push_back('{cyc - c0, int'(bus.b_rd_addr), 0});
      if (bus.cfg_ld_en) cfg_q.push_back('{cyc - c0, int'(bus.cfg_ld_idx), int'(bus.cfg_ld_bias)});
      if (bus.win_valid && bus.win_ready)
        acc_q.push_back('{cyc - c0, int'(bus.win_row), int'(bus.win_col)});
      if (bus.res_wr_en) res_q.push_back('{cyc - c0, int'(bus.res_row), int'(bus.res_col)});
      if (bus.done)      done_q.push_back('{cyc - c0, 0, 0});
      if (prev_stall && (!bus.win_valid || bus.win_row != prev_row || bus.win_col != prev_col))
        stab_err <= stab_err + 1;
      prev_stall <= bus.win_valid && !bus.win_ready;
      prev_row   <= bus.win_row;
      prev_col   <= bus.win_col;
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr, bus.b_rd_en, bus.b_rd_addr,
                bus.cfg_ld_en, bus.cfg_ld_bias, bus.cfg_ld_idx, bus.win_valid, bus.win_row,
                bus.win_col, bus.res_wr_en, bus.res_row, bus.res_col});
  endfunction

  task automatic clear_logs();
    w_q.delete(); b_q.delete(); cfg_q.delete();
    acc_q.delete(); res_q.delete(); done_q.delete();
  endtask

  // mode 0 ready=1, 1 random ready, 2 hold last window 50 cycles, 3 exactly 37
  // random stalls, 4 abort with reset at window (10,5), 5 ready=1 + stray starts.
  task automatic run_layer(input int mode, output int fin);
    int rel, hold, stalls;
    fin = 0; hold = 0; stalls = 0;
    clear_logs();
    stab_base = stab_err;
    @(posedge clk); #1;
    c0 = cyc;
    bus.start = 1'b1;
    bus.win_ready = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      rel = cyc - c0;
      bus.start = (mode == 5) && (rel == 20 || rel == 300 || rel == 981 + PL);
      case (mode)
        1: bus.win_ready = 1'($urandom_range(0, 1));
        2: if (bus.win_valid && bus.win_row == 5'd29 && bus.win_col == 5'd29 && hold < 50) begin
             bus.win_ready = 1'b0; hold++;
           end else bus.win_ready = 1'b1;
        3: if (bus.win_valid && stalls < 37 && $urandom_range(0, 3) == 0) begin
             bus.win_ready = 1'b0; stalls++;
           end else bus.win_ready = 1'b1;
        4: begin
             bus.win_ready = 1'b1;
             if (bus.win_valid && bus.win_row == 5'd10 && bus.win_col == 5'd5) begin
               rst = 1'b0; fin = 2; break;
             end
           end
        default: bus.win_ready = 1'b1;
      endcase
      if (done_q.size() > 0 && rel > done_q[0].cyc + 1) begin
        fin = 1; break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_layer_run(input int mode);
    int bad, exp_done;
    bad = (w_q.size() != 72);
    foreach (w_q[i]) if (w_q[i].a != i || w_q[i].cyc != i + 1) bad++;
    nchk++;
    if (bad !== 0) begin nerr++;
      $display("FAIL w_reads: %0d bad, %0d reads seen; required 0 bad, 72 reads", bad, w_q.size()); end

    bad = (b_q.size() != 8);
    foreach (b_q[i]) if (b_q[i].a != i || b_q[i].cyc != 73 + i) bad++;
    nchk++;
    if (bad !== 0) begin nerr++;
      $display("FAIL b_reads: %0d bad, %0d reads seen; required 0 bad, 8 reads", bad, b_q.size()); end

    bad = (cfg_q.size() != 80);
    foreach (cfg_q[i])
      if (cfg_q[i].cyc != i + 2 || cfg_q[i].b != int'(i >= 72) ||
          cfg_q[i].a != ((i >= 72) ? i - 72 : i)) bad++;
    nchk++;
    if (bad !== 0) begin nerr++;
      $display("FAIL cfg_loads: %0d bad, %0d loads seen; required 0 bad, 80 loads", bad, cfg_q.size()); end

    bad = (acc_q.size() != NWIN);
    foreach (acc_q[k]) begin
      if (acc_q[k].a != k / OW || acc_q[k].b != k % OW) bad++;
      if ((mode == 0 || mode == 5) && acc_q[k].cyc != 81 + k) bad++;
      if (k == 0 && acc_q[k].cyc < 81) bad++;
      if (k > 0 && acc_q[k].cyc <= acc_q[k-1].cyc) bad++;
    end
    nchk++;
    if (bad !== 0) begin nerr++;
      $display("FAIL window_order: %0d bad, %0d accepts; required 0 bad, %0d accepts", bad, acc_q.size(), NWIN); end

    bad = (res_q.size() != NWIN);
    foreach (res_q[k]) begin
      if (res_q[k].a != k / OW || res_q[k].b != k % OW) bad++;
      if (k < acc_q.size() && res_q[k].cyc != acc_q[k].cyc + PL) bad++;
    end
    nchk++;
    if (bad !== 0) begin nerr++;
      $display("FAIL results: %0d bad, %0d writes; required 0 bad, %0d writes", bad, res_q.size(), NWIN); end

    if (mode == 0 || mode == 5) exp_done = 981 + PL;
    else if (mode == 2)         exp_done = 1031 + PL;
    else                        exp_done = (acc_q.size() > 0) ? acc_q[$].cyc + PL + 1 : -1;
    nchk++;
    if (done_q.size() != 1 || done_q[0].cyc !== exp_done) begin nerr++;
      $display("FAIL done_cycle: %0d pulses, first at %0d; required 1 pulse at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0].cyc : -1, exp_done); end

    nchk++;
    if (stab_err - stab_base !== 0) begin nerr++;
      $display("FAIL stall_stable: %0d coord changes while stalled; required 0", stab_err - stab_base); end

    nchk++;
    if (bus.busy !== 1'b0) begin nerr++;
      $display("FAIL busy_after_done: got %b, required 0", bus.busy); end
  endtask

  task automatic check_fin(input string name, input int fin, input int want);
    nchk++;
    if (fin !== want) begin nerr++;
      $display("FAIL %s: run status %0d, required %0d", name, fin, want); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++;
    if (all_outs() !== 64'd0) begin nerr++;
      $display("FAIL reset_outs: got %h, required 0", all_outs()); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++;
    if (bus.busy !== 1'b0 || bus.win_valid !== 1'b0) begin nerr++;
      $display("FAIL idle_after_reset: busy=%b win_valid=%b, required 0 0", bus.busy, bus.win_valid); end
  endtask

  task automatic test_full_run();
    int fin;
    run_layer(0, fin);
    check_fin("full_run_complete", fin, 1);
    check_layer_run(0);
  endtask

  task automatic test_random_ready();
    int fin;
    for (int r = 0; r < 2; r++) begin
      run_layer(1, fin);
      check_fin("random_run_complete", fin, 1);
      check_layer_run(1);
    end
  endtask

  task automatic test_start_ignored();
    int fin;
    run_layer(5, fin);
    check_fin("stray_start_complete", fin, 1);
    check_layer_run(5);
    repeat (5) @(posedge clk);
    #1;
    nchk++;
    if (bus.busy !== 1'b0 || w_q.size() != 72 || done_q.size() != 1) begin nerr++;
      $display("FAIL start_at_done_ignored: busy=%b reads=%0d dones=%0d, required 0 72 1",
               bus.busy, w_q.size(), done_q.size()); end
  endtask

  task automatic test_reset_mid();
    int fin;
    run_layer(4, fin);
    check_fin("abort_point_reached", fin, 2);
    #1;
    nchk++;
    if (all_outs() !== 64'd0) begin nerr++;
      $display("FAIL abort_outs: got %h, required 0", all_outs()); end
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    nchk++;
    if (res_q.size() != 0 || done_q.size() != 0 || bus.busy !== 1'b0) begin nerr++;
      $display("FAIL abort_discard: writes=%0d dones=%0d busy=%b, required 0 0 0",
               res_q.size(), done_q.size(), bus.busy); end
    run_layer(0, fin);
    check_fin("restart_complete", fin, 1);
    check_layer_run(0);
  endtask

  task automatic test_last_stall();
    int fin;
    run_layer(2, fin);
    check_fin("last_stall_complete", fin, 1);
    check_layer_run(2);
    nchk++;
    if (acc_q.size() == 0 || acc_q[$].cyc !== 1030) begin nerr++;
      $display("FAIL last_accept_cycle: got %0d, required 1030",
               (acc_q.size() > 0) ? acc_q[$].cyc : -1); end
  endtask

`ifdef CNN_SCHED_PERF_EN
  task automatic test_perf();
    int fin;
    run_layer(3, fin);
    check_fin("perf_run_complete", fin, 1);
    check_layer_run(3);
    nchk++;
    if (bus.perf_stall !== 16'd37) begin nerr++;
      $display("FAIL perf_count: got %0d, required 37", bus.perf_stall); end
    repeat (5) @(posedge clk);
    #1;
    nchk++;
    if (bus.perf_stall !== 16'd37) begin nerr++;
      $display("FAIL perf_hold: got %0d, required 37", bus.perf_stall); end
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    nchk++;
    if (bus.perf_stall !== 16'd0 || bus.busy !== 1'b1) begin nerr++;
      $display("FAIL perf_clear: perf=%0d busy=%b, required 0 1", bus.perf_stall, bus.busy); end
    for (int n = 0; n < 3000 && bus.busy; n++) begin
      @(posedge clk); #1;
    end
    nchk++;
    if (bus.busy !== 1'b0 || bus.perf_stall !== 16'd0) begin nerr++;
      $display("FAIL perf_clean_run: busy=%b perf=%0d, required 0 0", bus.busy, bus.perf_stall); end
  endtask
`endif

  initial begin
    bus.start     = 1'b0;
    bus.win_ready = 1'b0;
    test_reset();
    test_full_run();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
    test_last_stall();
`ifdef CNN_SCHED_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
